// File: rtl/eth_firewall.sv
// rtl/eth_firewall.sv - Ethernet RX destination-MAC filter that strips the 14-byte header
// Optional FIREWALL_STATS_EN adds frames_accepted/frames_dropped counters.
module eth_firewall #(
  parameter logic [47:0] MAC_ADDR = 48'h69695A065491
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiov,
  output logic [1:0] axiod
`ifdef FIREWALL_STATS_EN
  ,
  output logic [15:0] frames_accepted,
  output logic [15:0] frames_dropped
`endif
);

  typedef enum logic [2:0] {WAIT_GAP, DST, HDR_SKIP, PAYLOAD, DROP} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic       match_mac;
  logic       match_bcast;
  logic [4:0] dst_idx;
  logic [1:0] mac_dibit;
  logic       mac_hit;
  logic       bcast_hit;
  logic       decide;
  logic       keep;

  // dst_idx is clamped so the MAC lookup stays in range outside the DST phase
  always_comb begin
    dst_idx   = (cnt < 6'd24) ? cnt[4:0] : 5'd0;
    mac_dibit = 2'(MAC_ADDR >> (6'd46 - {dst_idx, 1'b0}));
    mac_hit   = match_mac & (axiid == mac_dibit);
    bcast_hit = match_bcast & (axiid == 2'b11);
    keep      = mac_hit | bcast_hit;
    decide    = axiiv & (state == DST) & (cnt == 6'd23);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_GAP;
      cnt         <= 6'd0;
      match_mac   <= 1'b1;
      match_bcast <= 1'b1;
      axiov       <= 1'b0;
      axiod       <= 2'b00;
    end else if (!axiiv) begin
      state       <= DST;
      cnt         <= 6'd0;
      match_mac   <= 1'b1;
      match_bcast <= 1'b1;
      axiov       <= 1'b0;
    end else begin
      axiov <= (state == PAYLOAD);
      if (state == PAYLOAD) axiod <= axiid;
      case (state)
        DST: begin
          match_mac   <= mac_hit;
          match_bcast <= bcast_hit;
          cnt         <= cnt + 6'd1;
          if (cnt == 6'd23) state <= keep ? HDR_SKIP : DROP;
        end
        HDR_SKIP: begin
          // counter parks at 55 once the header has been consumed
          if (cnt == 6'd55) state <= PAYLOAD;
          else              cnt   <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIREWALL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_accepted <= 16'd0;
      frames_dropped  <= 16'd0;
    end else if (decide) begin
      if (keep) frames_accepted <= frames_accepted + 16'd1;
      else      frames_dropped  <= frames_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_firewall.sv
// tb/tb_eth_firewall.sv - scoreboard bench for eth_firewall with a frame-level reference model
module tb_eth_firewall;
  localparam logic [47:0] MAC   = 48'h69695A065491;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic       axiov;
  logic [1:0] axiod;
`ifdef FIREWALL_STATS_EN
  logic [15:0] frames_accepted;
  logic [15:0] frames_dropped;
`endif

  eth_firewall dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .axiov(axiov),
    .axiod(axiod)
`ifdef FIREWALL_STATS_EN
    ,
    .frames_accepted(frames_accepted),
    .frames_dropped(frames_dropped)
`endif
  );

  typedef struct {
    int         t;
    logic [1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_acc = 0;
  int   exp_drop = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid output must match the next expected dibit and its cycle
  always @(negedge clk) begin
    if (axiov) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got axiov=1 axiod=%b at cycle %0d, required no output", axiod, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.t != cyc || e.d != axiod) begin
          failures++;
          $display("FAIL out_dibit: got %b at cycle %0d, required %b at cycle %0d", axiod, cyc, e.d, e.t);
        end
      end
    end
  end

  task automatic build(input logic [47:0] dst, input int n_payload, output logic [7:0] b[$]);
    b = {};
    for (int k = 0; k < 6; k++) b.push_back(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) b.push_back(8'($urandom_range(0, 255)));
    b.push_back(8'h08);
    b.push_back(8'h00);
    for (int k = 0; k < n_payload; k++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  function automatic logic [1:0] dibit_of(input logic [7:0] b[$], input int i);
    logic [7:0] by;
    by = b[i/4];
    return 2'((by >> (6 - 2*(i%4))) & 8'h03);
  endfunction

  // Drive one frame; rst_dibit >= 0 pulses rst while that dibit is presented
  task automatic run_frame(input logic [7:0] b[$], input int rst_dibit, input int gap);
    int nd;
    logic [47:0] dst;
    logic pass;
    nd = b.size() * 4;
    dst = '0;
    for (int k = 0; k < 6 && k < b.size(); k++) dst = {dst[39:0], b[k]};
    pass = (b.size() >= 6) && (dst == MAC || dst == BCAST);
    if (nd >= 24) begin
      if (pass) exp_acc++;
      else      exp_drop++;
    end
    for (int i = 0; i < nd; i++) begin
      @(posedge clk);
      #1;
      rst   = (i == rst_dibit);
      axiiv = 1'b1;
      axiid = dibit_of(b, i);
      if (rst) begin
        exp_acc  = 0;
        exp_drop = 0;
      end
      if (pass && i >= 56 && (rst_dibit < 0 || i < rst_dibit))
        exp_q.push_back('{t: cyc + 1, d: axiid});
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      rst   = 1'b0;
      axiiv = 1'b0;
      axiid = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_stats(input string name);
`ifdef FIREWALL_STATS_EN
    @(negedge clk);
    checks++;
    if (frames_accepted != 16'(exp_acc)) begin
      failures++;
      $display("FAIL %s_accepted: got %0d, required %0d", name, frames_accepted, exp_acc);
    end
    checks++;
    if (frames_dropped != 16'(exp_drop)) begin
      failures++;
      $display("FAIL %s_dropped: got %0d, required %0d", name, frames_dropped, exp_drop);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    logic [7:0] b[$];
    logic [47:0] dst;
    int r;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (axiov !== 1'b0) begin failures++; $display("FAIL reset_axiov: got %b, required 0", axiov); end
    checks++;
    if (axiod !== 2'b00) begin failures++; $display("FAIL reset_axiod: got %b, required 00", axiod); end
    check_stats("reset");

    // Frame already in flight when reset releases must be ignored entirely
    build(MAC, 8, b);
    for (int i = 0; i < b.size()*4; i++) begin
      @(posedge clk);
      #1;
      rst   = (i < 10);
      axiiv = 1'b1;
      axiid = dibit_of(b, i);
    end
    @(posedge clk);
    #1;
    axiiv = 1'b0;
    check_stats("wait_gap");

    b = {};
    build(MAC, 0, b);
    b.push_back(8'hDE); b.push_back(8'hAD); b.push_back(8'hBE); b.push_back(8'hEF);
    run_frame(b, -1, 1);
    build(BCAST, 0, b);
    b.push_back(8'hDE); b.push_back(8'hAD); b.push_back(8'hBE); b.push_back(8'hEF);
    run_frame(b, -1, 1);
    build(48'h69695A065490, 46, b);
    run_frame(b, -1, 1);
    build(MAC, 5, b);   run_frame(b, -1, 1);
    build(48'h123456789ABC, 7, b); run_frame(b, -1, 1);
    build(BCAST, 3, b); run_frame(b, -1, 1);
    check_stats("directed");

    // Runts: 10 bytes, exactly 6 bytes (decision reached), 5 bytes (no decision)
    build(MAC, 0, b); while (b.size() > 10) void'(b.pop_back()); run_frame(b, -1, 1);
    build(48'h0, 0, b); while (b.size() > 6) void'(b.pop_back()); run_frame(b, -1, 1);
    build(MAC, 0, b); while (b.size() > 5) void'(b.pop_back()); run_frame(b, -1, 1);
    check_stats("runt");

    build(MAC, 20, b);
    run_frame(b, 64, 2);
    check_stats("mid_rst");
    build(MAC, 6, b);
    run_frame(b, -1, 1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: dst = MAC;
        1: dst = BCAST;
        2: dst = MAC ^ (48'd1 << $urandom_range(0, 47));
        3: dst = {$urandom(), 16'($urandom())};
        default: for (int k = 0; k < 6; k++)
                   dst[47-8*k -: 8] = ($urandom_range(0, 1) == 1) ? 8'hFF : MAC[47-8*k -: 8];
      endcase
      build(dst, $urandom_range(0, 30), b);
      if ($urandom_range(0, 5) == 0) while (b.size() > 3 + $urandom_range(0, 12)) void'(b.pop_back());
      run_frame(b, -1, $urandom_range(1, 3));
    end
    check_stats("random");

    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d expected dibits never output, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
